// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, funct
// codes, controller state encoding, ALU operation and ALU control encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } ctrl_state_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps aluop (and funct for R-type) to the ALU operation.
// Ports: funct (instr[5:0]), aluop (from FSM) -> alucontrol.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute
// across several cycles, driving every datapath select and write enable.
// Ports: clk, reset (sync, active-high), op/funct from the instruction
// register, zero from the ALU; outputs iord, memwrite, irwrite, regdst,
// memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol
);

  ctrl_state_t state, next_state, dec_state;
  logic        pcwrite, branch;
  logic [1:0]  aluop;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;

    // During reset the outputs show FETCH with every enable masked below.
    dec_state = reset ? S_FETCH : state;

    case (dec_state)
      S_FETCH: begin
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        alusrcb    = 2'b01;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    if (reset) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller for the multicycle MIPS datapath: it sequences one shared ALU, one unified instruction/data memory and the register file across several clock cycles per instruction. It decodes `op` and `funct` from the instruction register and drives every datapath mux select and write enable. It sits beside the multicycle datapath and takes the place of the single-cycle control path.

## Interface
Parameters:
- none; opcodes and state encodings come from the shared package.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  6  instruction[31:26], taken from the instruction register.
- `funct`  in  6  instruction[5:0].
- `zero`  in  1  ALU zero flag, same cycle.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write enable.
- `irwrite`  out  1  instruction register load enable.
- `regdst`  out  1  write register select: 1 = rd, 0 = rt.
- `memtoreg`  out  1  write-back data select: 1 = Data register, 0 = ALUOut.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcen`  out  1  PC load enable.
- `alucontrol`  out  3  ALU operation.

## Operation
- Moore FSM; all outputs except `pcen` are a pure function of the state register. `pcen = pcwrite | (branch & zero)`, where `pcwrite` and `branch` are internal.
- Any output not listed for a state below is 0.
- States and their asserted outputs:
  - FETCH: irwrite, pcwrite, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca, alusrcb=10, aluop=00.
  - MEMREAD: iord.
  - MEMWB: memtoreg, regwrite.
  - MEMWRITE: iord, memwrite.
  - EXECUTE: alusrca, aluop=10.
  - ALUWB: regdst, regwrite.
  - BRANCH: alusrca, aluop=01, pcsrc=01, branch.
  - ADDIEXEC: alusrca, alusrcb=10, aluop=00.
  - ADDIWB: regwrite.
  - JUMP: pcsrc=10, pcwrite.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw (100011) or sw (101011); →EXECUTE for R-type (000000); →BRANCH for beq (000100); →ADDIEXEC for addi (001000); →JUMP for j (000010).
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEXEC→ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH and JUMP all return to FETCH.
- Unknown opcode in DECODE: go to FETCH with no register or memory write, i.e. the instruction behaves as a nop. The PC has already advanced by 4.
- Illegal or unreachable state encoding: next state is FETCH and all enables are 0.
- ALU decode:
  - aluop 00 → 010 (add).
  - aluop 01 → 110 (sub).
  - aluop 10 → by funct: 100000 add=010, 100010 sub=110, 100100 and=000, 100101 or=001, 101010 slt=111. Any other funct → 010.
- `op` and `funct` are sampled only in DECODE, MEMADR and EXECUTE. The instruction register is stable in those states because `irwrite` is asserted only in FETCH.

## Timing
- Reset: on a rising edge with `reset`=1 the state becomes FETCH. While `reset`=1, `pcen`, `irwrite`, `regwrite` and `memwrite` are forced to 0, and all other outputs hold their FETCH values.
- The first fetch occurs in the first cycle after `reset` deasserts.
- Reset asserted mid-instruction: the FSM returns to FETCH on the next edge. No write enable is asserted in the reset cycle.
- Cycles per instruction (FETCH through the last state, inclusive): lw 5; sw, R-type and addi 4; beq and j 3; unknown opcode 2.
- The beq decision uses `zero` combinationally in the BRANCH cycle. The PC updates on the edge leaving BRANCH only if `zero`=1.
- All writes commit on the rising edge that ends the state asserting them.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct localparams;
  - enum `ctrl_state_t` (4-bit);
  - the aluop and alucontrol encodings.
- Sub-module: reuse the existing `alu_decoder` (funct, aluop → alucontrol). The FSM, next-state logic and output decode stay in this module.

## Test plan
- Reset held 3 cycles, then released → state is FETCH; `pcen`=0 during reset; `pcen`=1, `irwrite`=1 and `alusrcb`=01 in the first cycle after release.
- lw (op=100011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; `iord`=1 in MEMREAD; `regwrite`=1 and `memtoreg`=1 only in MEMWB.
- R-type sub (funct=100010) → EXECUTE with `alucontrol`=110; ALUWB with `regdst`=1 and `regwrite`=1; 4 cycles total.
- beq with zero=1, then beq with zero=0 → in BRANCH, `pcen`=1 with `pcsrc`=01 for the first and `pcen`=0 for the second; back in FETCH on the next cycle in both cases.
- j, then op=111111 → j: JUMP with `pcsrc`=10 and `pcen`=1. op=111111: DECODE→FETCH with no `regwrite`/`memwrite` pulse.
- sw with reset asserted during MEMADR → `memwrite` never asserts; state is FETCH after the reset edge.
